// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS232 receive path and the CPU status word:
//   - ingest FSM state encoding (rx_state_t)
//   - default receive FIFO depth
//   - status-word bit positions, plus a helper that packs the status word
//     the same way the top-level inbus mux does
// No ports (package).
// -----------------------------------------------------------------------------
package rs232_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } rx_state_t;

  localparam int DEFAULT_DEPTH = 16;

  // Status word layout at I/O address 3.
  localparam int STAT_RDY_RX    = 0;
  localparam int STAT_RDY_TX    = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_MSB = 15;

  function automatic logic [15:0] status_word(input logic       rdy_rx,
                                              input logic       rdy_tx,
                                              input logic       full,
                                              input logic [7:0] level);
    logic [15:0] w;
    w                                = '0;
    w[STAT_RDY_RX]                   = rdy_rx;
    w[STAT_RDY_TX]                   = rdy_tx;
    w[STAT_FULL]                     = full;
    w[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level;
    return w;
  endfunction

endpackage

// File: rtl/rs232_rxfifo_if.sv
// -----------------------------------------------------------------------------
// rs232_rxfifo_if
// Bundles the RS232R handshake and the CPU-side FIFO signals.
//   rx_data[7:0], rx_rdy : byte offered by RS232R
//   rx_done              : one-cycle acknowledge back to RS232R
//   pop                  : CPU read strobe for the head byte
//   dout[7:0], valid     : head byte (first-word fall-through), non-empty flag
//   full, level[LW-1:0]  : occupancy status
// Modports: slave = the FIFO, master = the surrounding system/bench.
// -----------------------------------------------------------------------------
interface rs232_rxfifo_if
  import rs232_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          rx_done;
  logic          pop;
  logic [7:0]    dout;
  logic          valid;
  logic          full;
  logic [LW-1:0] level;

  modport slave (
    input  rx_data, rx_rdy, pop,
    output rx_done, dout, valid, full, level
  );

  modport master (
    output rx_data, rx_rdy, pop,
    input  rx_done, dout, valid, full, level
  );

endinterface

// File: rtl/rxfifo_mem.sv
// -----------------------------------------------------------------------------
// rxfifo_mem
// DEPTH x 8 storage: synchronous write, asynchronous (combinational) read,
// so it maps onto distributed RAM.
//   clk         : clock
//   we          : write enable
//   waddr/wdata : write port
//   raddr/rdata : combinational read port
// -----------------------------------------------------------------------------
module rxfifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and a reset would stop it mapping onto RAM.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rs232_rxfifo.sv
// -----------------------------------------------------------------------------
// rs232_rxfifo
// Receive byte FIFO between RS232R and the CPU I/O bus. Drains RS232R through
// its rdy/done handshake, stores bytes in a power-of-two circular buffer and
// presents the head byte first-word fall-through.
//   clk    : system clock
//   rst    : synchronous, active-high reset
//   bus    : rs232_rxfifo_if.slave (handshake, head byte, occupancy)
//   rts_n  : registered flow-control output, active low, with two-entry
//            hysteresis; exists only when RS232_RXFIFO_RTS_EN is defined
// Parameters: DEPTH (power of two, 2..256), RTS_LEVEL (flow-control threshold).
// -----------------------------------------------------------------------------
module rs232_rxfifo
  import rs232_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int RTS_LEVEL = DEPTH - 4
) (
  input  logic clk,
  input  logic rst,
`ifdef RS232_RXFIFO_RTS_EN
  output logic rts_n,
`endif
  rs232_rxfifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
      RTS_LEVEL < 2 || RTS_LEVEL > DEPTH) begin : g_bad_param
    $error("rs232_rxfifo: DEPTH must be a power of two in 2..256 and RTS_LEVEL in 2..DEPTH");
  end

  rx_state_t     state, state_next;
  logic [LW-1:0] wptr, rptr, level;
  logic          push, do_pop, rx_done_q;
  logic [7:0]    rdata;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level       = wptr - rptr;
  assign bus.level   = level;
  assign bus.full    = (level == DEPTH_L);
  assign bus.valid   = (level != '0);
  assign bus.rx_done = rx_done_q;
  assign do_pop      = bus.pop & bus.valid;
  assign bus.dout    = bus.valid ? rdata : 8'h00;

  // Ingest FSM. WAIT holds off until RS232R drops rdy, so a byte that has
  // already been acknowledged is never ingested twice.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE: if (bus.rx_rdy && !bus.full) begin
        push       = 1'b1;
        state_next = ACK;
      end
      ACK:  state_next = WAIT;
      WAIT: if (!bus.rx_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      rx_done_q <= 1'b0;
    end else begin
      state     <= state_next;
      rx_done_q <= push;
      if (push)   wptr <= wptr + LW'(1);
      if (do_pop) rptr <= rptr + LW'(1);
    end
  end

  rxfifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

`ifdef RS232_RXFIFO_RTS_EN
  localparam logic [LW-1:0] RTS_HI = LW'(RTS_LEVEL);
  localparam logic [LW-1:0] RTS_LO = LW'(RTS_LEVEL - 2);

  // Decide on the post-edge occupancy so rts_n tracks level without lag.
  logic [LW-1:0] level_next;
  assign level_next = (wptr + LW'(push)) - (rptr + LW'(do_pop));

  always_ff @(posedge clk) begin
    if (rst)                       rts_n <= 1'b0;
    else if (level_next >= RTS_HI) rts_n <= 1'b1;
    else if (level_next <  RTS_LO) rts_n <= 1'b0;
  end
`endif

endmodule

// File: doc/rs232_rxfifo.md
# rs232_rxfifo

Receive-side byte FIFO between the RS232R receiver and the CPU I/O bus at addresses 2 and 3. It absorbs bursts from the serial line so the CPU can poll less often without losing characters.

- Drains RS232R through its `rdy`/`done` handshake.
- Stores bytes in a power-of-two circular buffer.
- Presents the head byte, first-word fall-through, to the inbus mux.
- Reports occupancy in the status word.

## Interface
Parameters:
- `DEPTH`, default 16: buffer entries. Must be a power of two, 2..256.
- `RTS_LEVEL`, default `DEPTH-4`: occupancy at or above which `rts_n` deasserts. Used only with flow control enabled.

Ports (`LW = $clog2(DEPTH)+1`):
- `clk`  in  1: system clock, the same 25 MHz clock as the CPU.
- `rst`  in  1: synchronous, active-high reset. The top level drives `~rst`.
- `rx_data`  in  8: byte from RS232R.
- `rx_rdy`  in  1: RS232R holds a byte. Stays high until it is acknowledged.
- `rx_done`  out  1: one-cycle acknowledge pulse to RS232R `done`.
- `pop`  in  1: CPU read strobe, `rd & ioenb & (iowadr==2)`.
- `dout`  out  8: head byte. Valid while `valid` is high.
- `valid`  out  1: FIFO not empty. Replaces `rdyRx` in the status word.
- `full`  out  1: occupancy equals `DEPTH`.
- `level`  out  `LW`: current occupancy, 0..`DEPTH`.
- `rts_n`  out  1: flow-control output, active low. Present only with `RS232_RXFIFO_RTS_EN`.

## Operation
Ingest state machine, states `IDLE`, `ACK`, `WAIT`:
- `IDLE` with `rx_rdy & !full`:
  - write `rx_data` at `wptr`, increment `wptr`;
  - register `rx_done=1`;
  - go to `ACK`.
- `IDLE` with `rx_rdy & full`:
  - stay in `IDLE` and do not acknowledge;
  - the byte stays in RS232R and a following byte overwrites it there;
  - no sticky overrun is recorded, because it cannot be detected here.
- `ACK`: `rx_done=0`, go to `WAIT`.
- `WAIT`: go to `IDLE` when `rx_rdy=0`. This guards against re-ingesting a stale `rdy`.

Pop:
- `pop & valid` increments `rptr` on the clock edge.
- `pop` while empty is ignored; `level` is unchanged.

Storage and head output:
- `dout` = `mem[rptr]` read combinationally (distributed RAM).
- `dout` is undefined while `!valid`, but is driven to 0 in simulation.

Pointers and occupancy:
- `wptr` and `rptr` are `LW` bits wide and wrap modulo `2*DEPTH`.
- `level = wptr - rptr` in `LW`-bit arithmetic.
- `full = (level == DEPTH)`; `valid = (level != 0)`.

Simultaneous push and pop in one cycle: both pointers advance and `level` is unchanged. This is legal even when `full`, but ingest decides on the pre-edge `full`, so no push is taken that cycle.

## Timing
Reset values:
- state `IDLE`, `wptr=rptr=0`;
- `rx_done=0`, `valid=0`, `full=0`, `level=0`;
- `rts_n=0` (asserted, ready to receive).

Reset mid-handshake discards FIFO contents and returns to `IDLE`. If `rx_rdy` is still high it is acknowledged afresh from the cycle after reset.

Latency:
- Edge N: `rx_rdy` is sampled high in `IDLE`.
- `rx_done` is high during cycle N+1.
- `valid` and `level` update after edge N, so the byte is visible to the CPU in cycle N+1.

Throughput: at most one byte per 3 clocks. RS232R delivers far slower than this.

Pop effect: `pop` at edge N changes `dout`, `valid` and `level` from cycle N+1.

## Configuration
`RS232_RXFIFO_RTS_EN`:
- **Defined:**
  - `rts_n` output exists and is registered;
  - `rts_n` goes to 1 when `level >= RTS_LEVEL` after an edge;
  - `rts_n` returns to 0 when `level < RTS_LEVEL-2` (two-entry hysteresis);
  - the top level routes `rts_n` to a GPIO header pin.
- **Undefined:** the port and its logic are absent, and `RTS_LEVEL` is unused.

## Structure
- Shared package `rs232_pkg` holds:
  - state encoding `IDLE=2'd0`, `ACK=2'd1`, `WAIT=2'd2`;
  - default `DEPTH`;
  - the status-word bit positions (`rdyRx`=0, `rdyTx`=1, `full`=2, `level`=[15:8]), also used by the top-level mux.
- One sub-module, `rxfifo_mem`: `DEPTH`x8 memory with synchronous write and asynchronous read. Ports: `clk`, `we`, `waddr`, `wdata`, `raddr`, `rdata`.

## Test plan
1. **Reset:** hold `rst=1` for 3 cycles with `rx_rdy=1` -> `rx_done=0`, `level=0`, `valid=0` throughout; first `rx_done` pulse appears 2 cycles after `rst` falls.
2. **Single byte:** `rx_data=8'h41`, `rx_rdy` pulse handshake -> one `rx_done` pulse; `dout=8'h41`, `level=1`; `pop` -> `valid=0` next cycle.
3. **Fill and order:** push 16 bytes 0x00..0x0F, then hold a 17th with `rx_rdy=1` -> `full=1`, no `rx_done`; pop all -> bytes read back 0x00..0x0F in order; 17th acknowledged after the first pop.
4. **Wrap-around:** 40 push/pop interleavings with `DEPTH=16` -> data intact across pointer wrap; `level` never exceeds 16.
5. **Simultaneous push and pop at `level=5`** -> `level` stays 5; head advances by one.
6. **Flow control (`RS232_RXFIFO_RTS_EN`, `RTS_LEVEL=12`):** fill to 12 -> `rts_n=1`; pop to 10 -> `rts_n` still 1; pop to 9 -> `rts_n=0`.
